// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller: state encoding, halt sentinel,
// and the per-state output decode used by the FSM.
package run_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFEFE_FEFE;

  typedef struct packed {
    logic src_ready;
    logic core_reset;
    logic busy;
    logic done;
  } flags_t;

  // Output levels that hold for the whole time the FSM sits in a state.
  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    f.src_ready  = (s == S_LOAD);
    f.core_reset = (s != S_RUN);
    f.busy       = (s == S_LOAD) || (s == S_RUN);
    f.done       = (s == S_DONE);
    return f;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Run-cycle counter with synchronous clear, count enable and a flag that
// marks the last cycle allowed before the run limit.
module run_cycle_counter #(
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [CYCLE_W-1:0] count,
  output logic               limit_hit
);

  localparam logic [CYCLE_W-1:0] LIMIT = CYCLE_W'(MAX_CYCLES - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CYCLE_W'(1);
    end
  end

  assign limit_hit = (count == LIMIT);

endmodule

// File: rtl/run_controller.sv
// Loads a program into instruction memory, runs the core until halt or
// cycle limit. Define RUN_CTRL_CHECKSUM_EN to add the load_checksum output.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          CYCLE_W    = 16,
  parameter int          MAX_CYCLES = 1024,
  parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  src_valid,
  input  logic [31:0]           src_data,
  output logic                  src_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  input  logic [31:0]           core_instr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
`ifdef RUN_CTRL_CHECKSUM_EN
  output logic [31:0]           load_checksum,
`endif
  output logic [CYCLE_W-1:0]    cycle_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

  state_t                state;
  flags_t                flags;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] last_ptr;
  logic [ADDR_WIDTH:0]   len_sat;
  logic                  start_ok;
  logic                  halt;
  logic                  accept;
  logic                  limit_hit;
  logic                  count_en;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign halt     = (state == S_RUN) && (core_instr == HALT_WORD);
  assign accept   = flags.src_ready && src_valid;
  assign len_sat  = (prog_len > DEPTH) ? DEPTH : prog_len;

  // The timeout cycle itself is not counted; a halt cycle always is.
  assign count_en = (state == S_RUN) && (halt || !limit_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      flags    <= flags_of(S_IDLE);
      ptr      <= '0;
      last_ptr <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            ptr     <= '0;
            timeout <= 1'b0;
            if (prog_len != '0) begin
              last_ptr <= ADDR_WIDTH'(len_sat - (ADDR_WIDTH + 1)'(1));
              state    <= S_LOAD;
              flags    <= flags_of(S_LOAD);
            end else begin
              state <= S_RUN;
              flags <= flags_of(S_RUN);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            if (ptr == last_ptr) begin
              state <= S_RUN;
              flags <= flags_of(S_RUN);
            end
          end
        end
        S_RUN: begin
          if (halt) begin
            timeout <= 1'b0;
            state   <= S_DONE;
            flags   <= flags_of(S_DONE);
          end else if (limit_hit) begin
            timeout <= 1'b1;
            state   <= S_DONE;
            flags   <= flags_of(S_DONE);
          end
        end
        default: begin
          state <= S_IDLE;
          flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

  run_cycle_counter #(
    .CYCLE_W   (CYCLE_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .enable   (count_en),
    .count    (cycle_count),
    .limit_hit(limit_hit)
  );

  // Memory write path is zero-latency: the accepted word lands in the same cycle.
  assign src_ready  = flags.src_ready;
  assign imem_we    = accept;
  assign imem_addr  = ptr;
  assign imem_wdata = src_data;
  assign core_reset = flags.core_reset;
  assign busy       = flags.busy;
  assign done       = flags.done;

`ifdef RUN_CTRL_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_checksum <= '0;
    end else if (start_ok) begin
      load_checksum <= '0;
    end else if (accept) begin
      load_checksum <= load_checksum + src_data;
    end
  end
`endif

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus randomized
// loads/runs compared against a program-level reference model.
module tb_run_controller;

  localparam int          AW   = 4;
  localparam int          CW   = 16;
  localparam int          MAXC = 8;
  localparam logic [31:0] HALT = 32'hFEFE_FEFE;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   prog_len;
  logic          src_valid;
  logic [31:0]   src_data;
  logic          src_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic [31:0]   core_instr;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
`ifdef RUN_CTRL_CHECKSUM_EN
  logic [31:0]   load_checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prog [16];

  run_controller #(
    .ADDR_WIDTH(AW),
    .CYCLE_W   (CW),
    .MAX_CYCLES(MAXC),
    .HALT_WORD (HALT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_len   (prog_len),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .core_instr (core_instr),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
`ifdef RUN_CTRL_CHECKSUM_EN
    .load_checksum(load_checksum),
`endif
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] non_halt();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = ~v;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_src_ready"}, 32'(src_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
  endtask

  task automatic start_prog(input int len);
    start    = 1'b1;
    prog_len = (AW + 1)'(len);
    step();
    start = 1'b0;
  endtask

  // Streams prog[0..n-1]; word stall_idx gets exactly two idle cycles before it.
  task automatic load_prog(input int n, input int stall_max, input int stall_idx);
    for (int i = 0; i < n; i++) begin
      int stalls;
      stalls = (i == stall_idx) ? 2 : int'($urandom_range(stall_max, 0));
      for (int s = 0; s < stalls; s++) begin
        src_valid = 1'b0;
        src_data  = $urandom;
        #1;
        check("stall_we", 32'(imem_we), 32'd0);
        check("stall_ready", 32'(src_ready), 32'd1);
        check("stall_addr", 32'(imem_addr), 32'(i));
        step();
      end
      src_valid = 1'b1;
      src_data  = prog[i];
      #1;
      check("load_we", 32'(imem_we), 32'd1);
      check("load_addr", 32'(imem_addr), 32'(i));
      check("load_wdata", imem_wdata, prog[i]);
      check("load_core_reset", 32'(core_reset), 32'd1);
      check("load_busy", 32'(busy), 32'd1);
      step();
    end
    src_valid = 1'b0;
  endtask

  // halt_at: 1-based run cycle presenting the halt word; 0 means never.
  task automatic run_prog(input int halt_at, input bit poke_start);
    int exp_len;
    int exp_cnt;
    bit exp_to;
    if (halt_at >= 1 && halt_at <= MAXC) begin
      exp_len = halt_at;
      exp_to  = 1'b0;
      exp_cnt = halt_at;
    end else begin
      exp_len = MAXC;
      exp_to  = 1'b1;
      exp_cnt = MAXC - 1;
    end
    for (int c = 1; c <= exp_len; c++) begin
      check("run_core_reset", 32'(core_reset), 32'd0);
      check("run_done", 32'(done), 32'd0);
      check("run_busy", 32'(busy), 32'd1);
      check("run_src_ready", 32'(src_ready), 32'd0);
      check("run_count", 32'(cycle_count), 32'(c - 1));
      if (c == 1) check("run_timeout_clear", 32'(timeout), 32'd0);
      core_instr = (c == halt_at) ? HALT : non_halt();
      if (poke_start && c == 2) begin
        start    = 1'b1;
        prog_len = (AW + 1)'(3);
      end
      step();
      start = 1'b0;
    end
    core_instr = non_halt();
    check("end_done", 32'(done), 32'd1);
    check("end_timeout", 32'(timeout), 32'(exp_to));
    check("end_count", 32'(cycle_count), 32'(exp_cnt));
    check("end_core_reset", 32'(core_reset), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("hold_done", 32'(done), 32'd1);
    check("hold_count", 32'(cycle_count), 32'(exp_cnt));
    check("hold_timeout", 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    prog_len   = '0;
    src_valid  = 1'b0;
    src_data   = '0;
    core_instr = '0;
    #2;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b0;
    step();
    check_reset_values("idle");

    // Three words back-to-back, halt on the fifth run cycle.
    prog[0] = 32'hAAAA_0001;
    prog[1] = 32'hBBBB_0002;
    prog[2] = 32'hCCCC_0003;
    start_prog(3);
    check("load_entry_ready", 32'(src_ready), 32'd1);
    check("load_entry_busy", 32'(busy), 32'd1);
    load_prog(3, 0, -1);
    run_prog(5, 1'b0);

    // Two-cycle stall before the middle word, then run to the cycle limit.
    for (int i = 0; i < 3; i++) prog[i] = $urandom;
    start_prog(3);
    load_prog(3, 0, 1);
    run_prog(0, 1'b0);

    // Preloaded memory: straight to RUN, halt on the limit cycle, start ignored.
    start_prog(0);
    run_prog(MAXC, 1'b1);

    // Randomized programs and halt positions.
    for (int t = 0; t < 6; t++) begin
      int len;
      len = int'($urandom_range(16, 1));
      for (int i = 0; i < len; i++) prog[i] = $urandom;
      start_prog(len);
      load_prog(len, 2, -1);
      run_prog(int'($urandom_range(MAXC + 2, 0)), 1'b0);
    end

    // Oversized length saturates to the full memory depth.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    start_prog(20);
    load_prog(16, 1, -1);
    run_prog(3, 1'b0);

`ifdef RUN_CTRL_CHECKSUM_EN
    prog[0] = 32'd1;
    prog[1] = 32'd2;
    prog[2] = 32'd3;
    start_prog(3);
    check("csum_clear", load_checksum, 32'd0);
    load_prog(3, 0, -1);
    check("csum_sum", load_checksum, 32'd6);
    run_prog(1, 1'b0);
    check("csum_held", load_checksum, 32'd6);
`endif

    // Asynchronous reset in the middle of a load.
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    start_prog(5);
    load_prog(2, 0, -1);
    src_valid = 1'b1;
    src_data  = $urandom;
    reset     = 1'b1;
    #1;
    check_reset_values("mid_load_rst");
`ifdef RUN_CTRL_CHECKSUM_EN
    check("mid_load_rst_csum", load_checksum, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    check_reset_values("after_rst");

    src_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
